// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and architectural register file.
// Selects the write-back value from the MEM/WB bundle, commits it to a
// 32-entry register file with two combinational read ports, counts retired
// instructions and drives the per-cycle debug write-back trace.
// Optional feature macro: WB_BYPASS_EN makes both read ports write-first
// (a same-cycle commit to the read address is returned immediately).
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_rf_WB,
  input  logic [2:0]      wd_sel_WB,
  input  logic [AW-1:0]   wR_WB,
  input  logic [XLEN-1:0] ALU_result_WB,
  input  logic [XLEN-1:0] DMEM_rd_WB,
  input  logic [XLEN-1:0] imm_WB,
  input  logic [XLEN-1:0] PC_WB,
  input  logic [31:0]     instruction_WB,
  input  logic            stall_j_WB,
  input  logic [AW-1:0]   rR1,
  input  logic [AW-1:0]   rR2,
  output logic [XLEN-1:0] rD1,
  output logic [XLEN-1:0] rD2,
  output logic [XLEN-1:0] wD_WB,
  output logic [31:0]     retired,
  output logic            debug_wb_have_inst,
  output logic [XLEN-1:0] debug_wb_pc,
  output logic            debug_wb_ena,
  output logic [AW-1:0]   debug_wb_reg,
  output logic [XLEN-1:0] debug_wb_value
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [31:0]     retired_q;
  logic [31:0]     retired_d;
  logic            valid;
  logic            commit;

  // A zero instruction word is a bubble; squashed jump-shadow slots never retire.
  assign valid  = (instruction_WB != 32'd0) && !stall_j_WB;
  assign commit = valid && we_rf_WB && (wR_WB != '0);

  // Write-back value select; unused encodings yield zero.
  always_comb begin
    wD_WB = '0;
    case (wd_sel_WB)
      3'd0:    wD_WB = ALU_result_WB;
      3'd1:    wD_WB = DMEM_rd_WB;
      3'd2:    wD_WB = PC_WB + XLEN'(4);
      3'd3:    wD_WB = imm_WB;
      default: wD_WB = '0;
    endcase
  end

  // One word of storage per register; x0 is never enabled so it stays zero.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      // Commit the selected value to this register when addressed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_q[gi] <= '0;
        end else if (commit && (wR_WB == AW'(gi))) begin
          regs_q[gi] <= wD_WB;
        end
      end
    end
  endgenerate

  // Read port 1: x0 reads as zero, optionally write-first.
  always_comb begin
    rD1 = '0;
    if (rR1 != '0) begin
      rD1 = regs_q[rR1];
    end
`ifdef WB_BYPASS_EN
    if (commit && (rR1 == wR_WB) && (rR1 != '0)) begin
      rD1 = wD_WB;
    end
`endif
  end

  // Read port 2: identical behaviour to port 1.
  always_comb begin
    rD2 = '0;
    if (rR2 != '0) begin
      rD2 = regs_q[rR2];
    end
`ifdef WB_BYPASS_EN
    if (commit && (rR2 == wR_WB) && (rR2 != '0)) begin
      rD2 = wD_WB;
    end
`endif
  end

  // Retired count advances for every valid instruction, writing or not; wraps naturally.
  always_comb begin
    retired_d = retired_q;
    if (valid) begin
      retired_d = retired_q + 32'd1;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

  // Debug trace describes the instruction currently in WB.
  always_comb begin
    debug_wb_have_inst = valid;
    debug_wb_pc        = valid  ? PC_WB : '0;
    debug_wb_ena       = commit;
    debug_wb_reg       = commit ? wR_WB : '0;
    debug_wb_value     = commit ? wD_WB : '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed bench for wb_regfile with a reference register
// model and an expected-value scoreboard queue.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        we_rf_WB;
  logic [2:0]  wd_sel_WB;
  logic [4:0]  wR_WB;
  logic [31:0] ALU_result_WB;
  logic [31:0] DMEM_rd_WB;
  logic [31:0] imm_WB;
  logic [31:0] PC_WB;
  logic [31:0] instruction_WB;
  logic        stall_j_WB;
  logic [4:0]  rR1;
  logic [4:0]  rR2;
  logic [31:0] rD1;
  logic [31:0] rD2;
  logic [31:0] wD_WB;
  logic [31:0] retired;
  logic        debug_wb_have_inst;
  logic [31:0] debug_wb_pc;
  logic        debug_wb_ena;
  logic [4:0]  debug_wb_reg;
  logic [31:0] debug_wb_value;

  wb_regfile #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .we_rf_WB(we_rf_WB), .wd_sel_WB(wd_sel_WB), .wR_WB(wR_WB),
    .ALU_result_WB(ALU_result_WB), .DMEM_rd_WB(DMEM_rd_WB), .imm_WB(imm_WB),
    .PC_WB(PC_WB), .instruction_WB(instruction_WB), .stall_j_WB(stall_j_WB),
    .rR1(rR1), .rR2(rR2), .rD1(rD1), .rD2(rD2), .wD_WB(wD_WB),
    .retired(retired),
    .debug_wb_have_inst(debug_wb_have_inst), .debug_wb_pc(debug_wb_pc),
    .debug_wb_ena(debug_wb_ena), .debug_wb_reg(debug_wb_reg),
    .debug_wb_value(debug_wb_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q [$];
  logic [31:0] mdl [32];
  logic [31:0] mdl_ret;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic push(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp_v = sb_q.pop_front();
      assert (obs === exp_v) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  function automatic logic [31:0] sel_val(input logic [2:0] s, input logic [31:0] a,
                                          input logic [31:0] d, input logic [31:0] im,
                                          input logic [31:0] pc);
    case (s)
      3'd0:    return a;
      3'd1:    return d;
      3'd2:    return pc + 32'd4;
      3'd3:    return im;
      default: return 32'd0;
    endcase
  endfunction

  // Value a read port should show in the cycle of a (possible) commit.
  function automatic logic [31:0] port_exp(input logic [4:0] r, input logic c,
                                           input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (BYPASS && c && (r == wr)) return wd;
    return mdl[r];
  endfunction

  task automatic idle();
    we_rf_WB = 1'b0; wd_sel_WB = 3'd0; wR_WB = 5'd0;
    ALU_result_WB = 32'd0; DMEM_rd_WB = 32'd0; imm_WB = 32'd0;
    PC_WB = 32'd0; instruction_WB = 32'd0; stall_j_WB = 1'b0;
  endtask

  // Drive one WB instruction for one cycle; check comb outputs, then the count.
  task automatic wb(input logic we, input logic [2:0] sel, input logic [4:0] wr,
                    input logic [31:0] alu, input logic [31:0] dmem, input logic [31:0] imm,
                    input logic [31:0] pc, input logic [31:0] instr, input logic stall);
    logic v, c;
    logic [31:0] wd;
    we_rf_WB = we; wd_sel_WB = sel; wR_WB = wr; ALU_result_WB = alu;
    DMEM_rd_WB = dmem; imm_WB = imm; PC_WB = pc; instruction_WB = instr; stall_j_WB = stall;
    #1;
    v  = (instr != 32'd0) && !stall;
    c  = v && we && (wr != 5'd0);
    wd = sel_val(sel, alu, dmem, imm, pc);
    push(wd);                    check("wD_WB", wD_WB);
    push({31'd0, v});            check("have_inst", {31'd0, debug_wb_have_inst});
    push(v ? pc : 32'd0);        check("dbg_pc", debug_wb_pc);
    push({31'd0, c});            check("dbg_ena", {31'd0, debug_wb_ena});
    push(c ? {27'd0, wr} : 32'd0); check("dbg_reg", {27'd0, debug_wb_reg});
    push(c ? wd : 32'd0);        check("dbg_value", debug_wb_value);
    push(port_exp(rR1, c, wr, wd)); check("rD1_same_cycle", rD1);
    push(port_exp(rR2, c, wr, wd)); check("rD2_same_cycle", rD2);
    @(posedge clk);
    if (c) mdl[wr] = wd;
    if (v) mdl_ret = mdl_ret + 32'd1;
    #1;
    idle();
    push(mdl_ret);               check("retired", retired);
  endtask

  task automatic read_chk(input logic [4:0] a, input logic [4:0] b);
    rR1 = a; rR2 = b;
    #1;
    push(a == 5'd0 ? 32'd0 : mdl[a]); check($sformatf("rD1[x%0d]", a), rD1);
    push(b == 5'd0 ? 32'd0 : mdl[b]); check($sformatf("rD2[x%0d]", b), rD2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rR1 = 5'd0; rR2 = 5'd0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl_ret = 32'd0;
    rst_n = 1'b0;
    #12;
    push(32'd0); check("reset_retired", retired);
    push(32'd0); check("reset_dbg_ena", {31'd0, debug_wb_ena});
    @(negedge clk);
    rst_n = 1'b1;

    // All registers read zero after reset.
    for (int i = 0; i < 32; i++) read_chk(5'(i), 5'(31 - i));

    // ALU write to x5, then read back.
    rR1 = 5'd5; rR2 = 5'd5;
    wb(1'b1, 3'd0, 5'd5, 32'h1234_5678, 32'd0, 32'd0, 32'h0000_0100, 32'h00A0_0293, 1'b0);
    read_chk(5'd5, 5'd5);

    // Write-data select sweep into x6.
    rR1 = 5'd6; rR2 = 5'd0;
    for (int s = 1; s <= 5; s++) begin
      if (s == 4) continue;
      wb(1'b1, 3'(s), 5'd6, 32'h1111_1111, 32'hDEAD_BEEF, 32'hABCD_E000, 32'h0000_0FFC,
         32'h0000_0013, 1'b0);
      read_chk(5'd6, 5'd5);
    end

    // x0 write is discarded but still retires.
    wb(1'b1, 3'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h200, 32'h0000_0013, 1'b0);
    read_chk(5'd0, 5'd0);

    // Bubble and squashed jump slot: no write, no count.
    wb(1'b1, 3'd0, 5'd7, 32'hAAAA_AAAA, 32'd0, 32'd0, 32'h204, 32'd0, 1'b0);
    read_chk(5'd7, 5'd7);
    wb(1'b1, 3'd0, 5'd7, 32'hBBBB_BBBB, 32'd0, 32'd0, 32'h208, 32'h0000_0013, 1'b1);
    read_chk(5'd7, 5'd7);

    // Non-writing instruction (store) still counts.
    wb(1'b0, 3'd0, 5'd8, 32'hCCCC_CCCC, 32'd0, 32'd0, 32'h20C, 32'h0000_0023, 1'b0);
    read_chk(5'd8, 5'd8);

    // Same-cycle write/read of x9: old value first, then the new one.
    wb(1'b1, 3'd0, 5'd9, 32'h0000_0011, 32'd0, 32'd0, 32'h210, 32'h0000_0013, 1'b0);
    rR1 = 5'd5; rR2 = 5'd9;
    wb(1'b1, 3'd0, 5'd9, 32'h0000_0055, 32'd0, 32'd0, 32'h214, 32'h0000_0013, 1'b0);
    read_chk(5'd9, 5'd9);

    // Pseudo-random writes, then a full readback.
    for (int k = 0; k < 10; k++) begin
      rR1 = 5'($urandom_range(0, 31)); rR2 = 5'($urandom_range(0, 31));
      wb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
         $urandom, $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
         32'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 32; i++) read_chk(5'(i), 5'(i));

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    mdl_ret = 32'hFFFF_FFFF;
    push(32'hFFFF_FFFF); check("retired_preload", retired);
    wb(1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h300, 32'h0000_0013, 1'b0);

    // Reset mid-write: clears immediately and aborts the pending commit.
    rR1 = 5'd5; rR2 = 5'd12;
    we_rf_WB = 1'b1; wd_sel_WB = 3'd0; wR_WB = 5'd12; ALU_result_WB = 32'h7777_7777;
    instruction_WB = 32'h0000_0013; PC_WB = 32'h304;
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl_ret = 32'd0;
    #1;
    push(32'd0); check("rst_retired", retired);
    push(32'd0); check("rst_rD1_x5", rD1);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    read_chk(5'd12, 5'd6);
    push(32'd0); check("post_rst_retired", retired);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and architectural register file of the five-stage pipeline; the consuming end of the MEM/WB pipeline register.
- Selects the write-back value from the WB-stage bundle and commits it to a 32-entry register file.
- Serves the two ID-stage read ports.
- Maintains a retired-instruction counter and the per-cycle debug write-back trace.

Parameters:
XLEN, 32, data width of registers and datapath
NREG, 32, number of architectural registers
AW, 5, register address width (log2 NREG)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
we_rf_WB  input  1  register-file write enable from MEM/WB
wd_sel_WB  input  3  write-data select from MEM/WB
wR_WB  input  AW  destination register
ALU_result_WB  input  XLEN  ALU result
DMEM_rd_WB  input  XLEN  load data
imm_WB  input  XLEN  immediate (lui)
PC_WB  input  XLEN  PC of WB instruction
instruction_WB  input  32  instruction word; 0 = bubble
stall_j_WB  input  1  instruction is a squashed jump-shadow slot
rR1  input  AW  ID read address 1
rR2  input  AW  ID read address 2
rD1  output  XLEN  read data 1
rD2  output  XLEN  read data 2
wD_WB  output  XLEN  selected write-back value, for EX/ID forwarding
retired  output  32  retired-instruction count
debug_wb_have_inst  output  1  a valid instruction is in WB this cycle
debug_wb_pc  output  XLEN  PC of that instruction
debug_wb_ena  output  1  register file written this cycle
debug_wb_reg  output  AW  register written
debug_wb_value  output  XLEN  value written

Behaviour:
- Reset: all NREG registers = 0, retired = 0. Asynchronous assertion, synchronous deassertion by the system.
  - Combinational outputs follow their inputs during reset.
  - Reset asserted mid-write aborts that write.
- Write-data mux (combinational), wD_WB by wd_sel_WB:
  - 0 → ALU_result_WB
  - 1 → DMEM_rd_WB
  - 2 → PC_WB + 4 (modulo 2^XLEN)
  - 3 → imm_WB
  - 4-7 → 0
- valid = (instruction_WB != 0) && !stall_j_WB.
- Commit = valid && we_rf_WB && (wR_WB != 0).
  - On the rising edge with commit, regs[wR_WB] <= wD_WB.
  - Write latency 1 cycle.
- Register x0:
  - Reads always return 0.
  - Writes to x0 are discarded.
  - debug_wb_ena = 0 for an x0 write.
- Reads are combinational, rD = regs[rR].
  - Same-cycle write to the read address: behaviour per BYPASS option.
  - rR1 == rR2 is legal; both ports return identical data.
- Retired counter:
  - retired <= retired + 1 on every edge where valid; wraps 0xFFFFFFFF → 0.
  - Counts non-writing instructions (sw, branches) too.
- Debug outputs (combinational, current cycle):
  - debug_wb_have_inst = valid
  - debug_wb_pc = valid ? PC_WB : 0
  - debug_wb_ena = commit
  - debug_wb_reg = commit ? wR_WB : 0
  - debug_wb_value = commit ? wD_WB : 0
- we_rf_WB high with a bubble or stall_j_WB: no write, no count.

Optional Feature:
WB_BYPASS_EN
- Defined: read ports are write-first. If commit && rR == wR_WB && rR != 0, rD = wD_WB in the same cycle. ID therefore needs no WB-stage forwarding.
- Undefined: read ports return the pre-write register contents. The hazard unit forwards from wD_WB.

Test Plan:
- Reset, then read all 32 registers → every rD = 0; retired = 0; debug_wb_ena = 0.
- we_rf=1, wd_sel=0, wR=5, ALU_result=0x1234_5678, instr=0x00A00293 → next cycle rR1=5 gives 0x12345678; retired=1; debug_wb_reg=5 and value=0x12345678 during the commit cycle.
- wd_sel sweep 1/2/3 into x6, with DMEM_rd=0xDEADBEEF, PC=0x0000_0FFC, imm=0xABCDE000 → x6 = 0xDEADBEEF, then 0x00001000, then 0xABCDE000; wd_sel=5 → 0.
- Write x0 with 0xFFFFFFFF → rD for rR=0 stays 0, debug_wb_ena=0, retired still increments. Bubble (instr=0, we_rf=1, wR=7) → x7 unchanged, retired unchanged. stall_j_WB=1 → same.
- Same-cycle write x9=0x55 with rR2=9:
  - WB_BYPASS_EN defined → rD2 = 0x55 that cycle.
  - Undefined → old value that cycle, 0x55 the next.
- Preload retired to 0xFFFFFFFF via 2^32-1 valid instructions (or force), then one valid instruction → retired = 0. Assert rst_n mid-stream → retired = 0 and registers = 0 immediately.
